// File: rtl/vid_fetch_ctrl.sv
// vid_fetch_ctrl -- bus-master fetch scheduler for the video pixel FIFO.
//
// Purpose:
//   Keeps the pixel FIFO fed. When fetching is enabled, the frame is not yet
//   exhausted and the FIFO has room for a whole burst, it bids for the shared
//   bus. Once granted it issues a one-cycle burst read command, then writes
//   the returned read-data beats into the FIFO one cycle after each beat.
//   frame_start rewinds the fetch address to frame_base. If a burst is in
//   flight, that burst still runs to completion on the bus, but its remaining
//   beats are discarded.
//
// Optional feature (macro FETCH_TIMEOUT_EN):
//   When defined, a burst that stalls for TIMEOUT cycles without a beat is
//   abandoned. The address and word count advance as if the burst had
//   completed, and the sticky fetch_err flag is set. When undefined, DATA
//   waits indefinitely and fetch_err is tied 0.
//
// Ports:
//   clk, reset           clock, asynchronous active-high reset
//   enable               fetching allowed
//   frame_start          1-cycle pulse at vblank start
//   frame_base           frame buffer byte address, sampled on frame_start
//   fifo_level           current FIFO occupancy, 0..DEPTH
//   ackin                bus grant
//   selin/cmdin          slave response select / command (3'b011 = read beat)
//   addrdatain           read beat payload
//   reqout               bus bid: 00 none, 01 normal, 11 urgent
//   reqtar               target slave id (4'h1) while bidding
//   lenout               burst length code (log2 BURST) during the command
//   cmdout               3'b010 read request during the command cycle
//   addrdataout          request address during the command cycle
//   fifo_write           FIFO write strobe
//   fifo_wdata           FIFO write data
//   busy                 FSM not idle
//   fetch_err            sticky timeout flag
module vid_fetch_ctrl #(
  parameter int DEPTH       = 16,
  parameter int BURST       = 4,
  parameter int LOW_WATER   = 8,
  parameter int FRAME_WORDS = 1024,
  parameter int TIMEOUT     = 64
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic                      frame_start,
  input  logic [31:0]               frame_base,
  input  logic [$clog2(DEPTH):0]    fifo_level,
  input  logic                      ackin,
  input  logic                      selin,
  input  logic [2:0]                cmdin,
  input  logic [31:0]               addrdatain,
  output logic [1:0]                reqout,
  output logic [3:0]                reqtar,
  output logic [1:0]                lenout,
  output logic [2:0]                cmdout,
  output logic [31:0]               addrdataout,
  output logic                      fifo_write,
  output logic [31:0]               fifo_wdata,
  output logic                      busy,
  output logic                      fetch_err
);

  localparam int LVL_W = $clog2(DEPTH) + 1;
  localparam int WC_W  = $clog2(FRAME_WORDS + 1);
  localparam int BC_W  = $clog2(BURST) + 1;

  localparam logic [1:0]  LEN_CODE  = 2'($clog2(BURST));
  localparam logic [31:0] ADDR_STEP = 32'(4 * BURST);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] ADDR = 2'd2;
  localparam logic [1:0] DATA = 2'd3;

  logic [1:0]      state;
  logic [31:0]     addr;
  logic [WC_W-1:0] word_cnt;
  logic [BC_W-1:0] beat_cnt;
  logic            drop;
  logic [31:0]     base_pend;

  logic            vld_p1;
  logic [31:0]     wdata_p1;

  logic            beat;
  logic            last_beat;
  logic            space_ok;
  logic            urgent;
  logic            frame_left;
  logic            start_ok;
  logic            timeout_hit;
  logic            burst_done;
  logic            abort_req;
  logic            frame_hit;
  logic [31:0]     reload_base;

  assign beat       = (state == DATA) && selin && (cmdin == 3'b011);
  assign last_beat  = beat && (beat_cnt == BC_W'(BURST - 1));
  assign space_ok   = fifo_level <= LVL_W'(DEPTH - BURST);
  assign urgent     = fifo_level < LVL_W'(LOW_WATER);
  assign frame_left = word_cnt < WC_W'(FRAME_WORDS);
  assign start_ok   = enable && frame_left && space_ok;
  assign abort_req  = (state == REQ) && !enable;
  assign burst_done = last_beat || timeout_hit;

  // A frame_start seen now or earlier in this burst discards the burst's
  // data and rewinds the address once the FSM returns to IDLE.
  assign frame_hit   = drop || frame_start;
  assign reload_base = frame_start ? frame_base : base_pend;

`ifdef FETCH_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT) + 1;

  logic [TMO_W-1:0] tmo_cnt;
  logic             err_q;

  assign timeout_hit = (state == DATA) && !beat && (tmo_cnt == TMO_W'(TIMEOUT - 1));
  assign fetch_err   = err_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmo_cnt <= '0;
      err_q   <= 1'b0;
    end else begin
      if (state != DATA || beat || timeout_hit)
        tmo_cnt <= '0;
      else
        tmo_cnt <= tmo_cnt + TMO_W'(1);
      if (timeout_hit)
        err_q <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign fetch_err   = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      addr      <= '0;
      word_cnt  <= '0;
      beat_cnt  <= '0;
      drop      <= 1'b0;
      base_pend <= '0;
      vld_p1    <= 1'b0;
      wdata_p1  <= '0;
    end else begin
      vld_p1 <= 1'b0;

      if (state == IDLE) begin
        if (frame_start) begin
          addr     <= frame_base;
          word_cnt <= '0;
        end
        if (start_ok)
          state <= REQ;
      end else if (frame_start) begin
        drop      <= 1'b1;
        base_pend <= frame_base;
      end

      case (state)
        REQ:  if (ackin) state <= ADDR;
        ADDR: state <= DATA;
        default: ;
      endcase

      // Stage p0 -> p1: accepted read beat registered toward the FIFO.
      if (beat) begin
        beat_cnt <= beat_cnt + BC_W'(1);
        if (!frame_hit) begin
          vld_p1   <= 1'b1;
          wdata_p1 <= addrdatain;
        end
      end

      // Leaving REQ/DATA for IDLE: either rewind for the new frame or step
      // past the burst just fetched (a dropped REQ bid fetched nothing).
      if (burst_done || abort_req) begin
        state    <= IDLE;
        beat_cnt <= '0;
        if (frame_hit) begin
          addr     <= reload_base;
          word_cnt <= '0;
          drop     <= 1'b0;
        end else if (burst_done) begin
          addr     <= addr + ADDR_STEP;
          word_cnt <= word_cnt + WC_W'(BURST);
        end
      end
    end
  end

  // Bus request signals are decoded straight from the state so the bid
  // tracks fifo_level every cycle and everything drops to 0 with reset.
  always_comb begin
    reqout      = 2'b00;
    reqtar      = 4'h0;
    lenout      = 2'b00;
    cmdout      = 3'b000;
    addrdataout = '0;
    if (state == REQ && enable) begin
      reqout = urgent ? 2'b11 : 2'b01;
      reqtar = 4'h1;
    end
    if (state == ADDR) begin
      cmdout      = 3'b010;
      addrdataout = addr;
      lenout      = LEN_CODE;
    end
  end

  assign busy       = (state != IDLE);
  assign fifo_write = vld_p1;
  assign fifo_wdata = wdata_p1;

endmodule
